sfft_r4_frame_ctrl: RTL and testbench
=====================================

SFFT_R4_FRAME_CTRL -- requirements
Module: sfft_r4_frame_ctrl

Interface
REQ-001 SHALL have parameter SIZE_BUFFER, default 4: log2(NFFT), with NFFT = 1<<SIZE_BUFFER and NFFT >= 4.
REQ-002 SHALL have parameter DATA_FFT_SIZE, default 16: I and Q sample width.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 256: maximum number of DRAIN cycles before a fault is raised.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  1-cycle run request; honoured only in IDLE.
REQ-007 stop  in  1  graceful stop; takes effect at the next frame boundary.
REQ-008 abort  in  1  immediate stop.
REQ-009 fault_clr  in  1  clears FAULT.
REQ-010 s_data_i, s_data_q  in  DATA_FFT_SIZE each  upstream sample.
REQ-011 s_valid  in  1  upstream sample valid.
REQ-012 s_ready  out  1  controller accepts a sample.
REQ-013 ic_data_i, ic_data_q  out  DATA_FFT_SIZE each  sample to the interconnect.
REQ-014 ic_valid  out  1  sample valid to the interconnect.
REQ-015 ic_counter_data  out  SIZE_BUFFER+1  sample index within the frame.
REQ-016 ic_done_n  in  1  interconnect drain-complete flag; active low; nominally a 1-cycle low pulse.
REQ-017 ic_reset  out  1  synchronous active-high reset to the interconnect.
REQ-018 busy  out  1  state != IDLE.
REQ-019 frame_done  out  1  1-cycle pulse per completed frame.
REQ-020 frame_cnt  out  16  count of completed frames.
REQ-021 fault  out  1  drain timeout occurred.
REQ-022 seq_err  out  1  sticky flag: ic_done_n was low outside DRAIN.

Function
REQ-023 SHALL implement a registered FSM with states IDLE=00, COLLECT=01, DRAIN=10, FAULT=11.
REQ-024 IDLE: start=1 SHALL move the FSM to COLLECT; the sample index SHALL be cleared on this transition.
REQ-025 s_ready SHALL be combinational: 1 only while state is COLLECT.
REQ-026 Beat definition: s_valid & s_ready.
REQ-027 ic_valid SHALL equal the beat condition.
REQ-028 ic_data_i and ic_data_q SHALL equal s_data_i and s_data_q combinationally, with zero latency.
REQ-029 ic_counter_data SHALL present the index of the current sample; MSB always 0; range 0..NFFT-1.
REQ-030 The index SHALL increment on every beat.
REQ-031 A beat at index NFFT-1 SHALL wrap the index to 0 and move the FSM to DRAIN on the next edge.
REQ-032 COLLECT with s_valid=0 SHALL hold the index unchanged; there is no timeout in COLLECT.
REQ-033 DRAIN: s_ready=0, and a watchdog counter SHALL start at 0 and increment every cycle.
REQ-034 DRAIN with ic_done_n sampled 0: frame_done SHALL pulse on the next cycle, frame_cnt SHALL increment, and frame_cnt SHALL wrap 0xFFFF->0.
REQ-035 From DRAIN on ic_done_n=0, the next state SHALL be IDLE if stop_pend=1, otherwise COLLECT; stop_pend SHALL then clear.
REQ-036 DRAIN with the watchdog reaching DRAIN_TIMEOUT-1 and no ic_done_n: the FSM SHALL move to FAULT and fault SHALL be set to 1.
REQ-037 If ic_done_n=0 arrives in the same cycle as the timeout, completion SHALL win.
REQ-038 stop=1 in COLLECT or DRAIN SHALL set stop_pend; stop=1 in IDLE SHALL be ignored.
REQ-039 A frame in progress SHALL always complete before a graceful stop takes effect.
REQ-040 abort=1 in any state except FAULT: next state SHALL be IDLE.
REQ-041 On abort, the index, watchdog and stop_pend SHALL clear, ic_reset SHALL pulse for exactly 1 cycle, and frame_cnt SHALL be unchanged.
REQ-042 abort SHALL take priority over start, stop and ic_done_n.
REQ-043 FAULT: s_ready=0; fault_clr=1 SHALL move the FSM to IDLE, clear fault, and pulse ic_reset for 1 cycle.
REQ-044 FAULT: abort SHALL be ignored.
REQ-045 ic_done_n=0 in IDLE, COLLECT or FAULT SHALL set seq_err and SHALL NOT change state.
REQ-046 seq_err SHALL clear only on reset or fault_clr.
REQ-047 start=1 outside IDLE SHALL be ignored.

Reset
REQ-048 reset=0 SHALL take effect asynchronously, with no clock edge required.
REQ-049 Reset values: state IDLE, index 0, watchdog 0, stop_pend 0, frame_cnt 0, fault 0, seq_err 0, frame_done 0, ic_reset 0.
REQ-050 While reset=0, s_ready=0 and ic_valid=0.
REQ-051 Reset deassertion SHALL be synchronised internally; the first operational edge is the second rising edge after reset=1.
REQ-052 Reset during COLLECT or DRAIN SHALL discard the partial frame, with no frame_done pulse.

Verification (NFFT=16, DRAIN_TIMEOUT=256)
REQ-053 start, then 16 beats with s_valid held 1 -> ic_counter_data 0..15; s_ready=0 from the cycle after the 16th beat; busy=1.
REQ-054 In DRAIN, ic_done_n low for 1 cycle -> frame_done pulses 1 cycle later, frame_cnt=1, FSM back in COLLECT, ic_counter_data=0.
REQ-055 stop at beat 5, then 11 more beats and ic_done_n -> frame_cnt increments, FSM goes to IDLE, s_ready=0.
REQ-056 DRAIN with ic_done_n held 1 for 256 cycles -> fault=1 and FSM in FAULT; fault_clr -> IDLE with ic_reset high for exactly 1 cycle.
REQ-057 abort at beat 9 -> IDLE next cycle, ic_reset pulses once, frame_cnt unchanged; a following start gives index 0.
REQ-058 ic_done_n low in IDLE -> seq_err=1, state stays IDLE; asynchronous reset in mid-COLLECT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sfft_r4_frame_ctrl_if.sv
// Sample stream and interconnect bus for the radix-4 SFFT frame controller.
// A beat occurs on any cycle where s_valid and s_ready are both high; s_valid
// may be raised without waiting for s_ready, and s_ready never depends on s_valid.
interface sfft_r4_frame_ctrl_if #(
  parameter int SIZE_BUFFER   = 4,
  parameter int DATA_FFT_SIZE = 16
);
  logic [DATA_FFT_SIZE-1:0] s_data_i;
  logic [DATA_FFT_SIZE-1:0] s_data_q;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_FFT_SIZE-1:0] ic_data_i;
  logic [DATA_FFT_SIZE-1:0] ic_data_q;
  logic                     ic_valid;
  logic [SIZE_BUFFER:0]     ic_counter_data;
  logic                     ic_done_n;
  logic                     ic_reset;

  modport master (
    output s_data_i, s_data_q, s_valid, ic_done_n,
    input  s_ready, ic_data_i, ic_data_q, ic_valid, ic_counter_data, ic_reset
  );

  modport slave (
    input  s_data_i, s_data_q, s_valid, ic_done_n,
    output s_ready, ic_data_i, ic_data_q, ic_valid, ic_counter_data, ic_reset
  );
endinterface

// File: rtl/sfft_r4_frame_ctrl.sv
// Frame controller: collects NFFT samples into the interconnect, waits for its
// drain-complete pulse, and supervises stop/abort/timeout behaviour.
module sfft_r4_frame_ctrl #(
  parameter int SIZE_BUFFER   = 4,
  parameter int DATA_FFT_SIZE = 16,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      abort,
  input  logic                      fault_clr,
  sfft_r4_frame_ctrl_if.slave       bus,
  output logic                      busy,
  output logic                      frame_done,
  output logic [15:0]               frame_cnt,
  output logic                      fault,
  output logic                      seq_err,
  output logic [1:0]                dbg_state_o
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] COLLECT = 2'b01;
  localparam logic [1:0] DRAIN   = 2'b10;
  localparam logic [1:0] FAULT   = 2'b11;

  localparam int                    WD_W     = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(DRAIN_TIMEOUT - 1);
  localparam logic [SIZE_BUFFER-1:0] IDX_LAST = '1;

  logic                   rst_sync_n_q;
  logic [1:0]             state_q, state_d;
  logic [SIZE_BUFFER-1:0] idx_q, idx_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   fault_q, fault_d;
  logic                   seq_err_q, seq_err_d;
  logic                   frame_done_q, frame_done_d;
  logic                   ic_reset_q, ic_reset_d;
  logic                   beat;
  logic                   done;

  // Assertion is immediate; release is retimed by one flop so the second
  // rising edge after reset=1 is the first one that moves the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_n_q <= 1'b0;
    else        rst_sync_n_q <= 1'b1;
  end

  assign bus.s_ready         = (state_q == COLLECT);
  assign beat                = bus.s_valid & bus.s_ready;
  assign bus.ic_valid        = beat;
  assign bus.ic_data_i       = bus.s_data_i;
  assign bus.ic_data_q       = bus.s_data_q;
  assign bus.ic_counter_data = {1'b0, idx_q};
  assign bus.ic_reset        = ic_reset_q;
  assign done                = ~bus.ic_done_n;

  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign fault       = fault_q;
  assign seq_err     = seq_err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    stop_pend_d  = stop_pend_q;
    frame_cnt_d  = frame_cnt_q;
    fault_d      = fault_q;
    frame_done_d = 1'b0;
    ic_reset_d   = 1'b0;
    seq_err_d    = seq_err_q | (done & (state_q != DRAIN));
    if (fault_clr) seq_err_d = 1'b0;

    if (abort && (state_q != FAULT)) begin
      state_d     = IDLE;
      idx_d       = '0;
      wd_d        = '0;
      stop_pend_d = 1'b0;
      ic_reset_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = COLLECT;
            idx_d   = '0;
          end
        end
        COLLECT: begin
          if (stop) stop_pend_d = 1'b1;
          if (beat) begin
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              wd_d    = '0;
              state_d = DRAIN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (stop) stop_pend_d = 1'b1;
          wd_d = wd_q + 1'b1;
          // Completion is checked first so it wins over a coincident timeout.
          if (done) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = (stop_pend_q | stop) ? IDLE : COLLECT;
            stop_pend_d  = 1'b0;
            wd_d         = '0;
            idx_d        = '0;
          end else if (wd_q == WD_LAST) begin
            state_d = FAULT;
            fault_d = 1'b1;
            wd_d    = '0;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            state_d    = IDLE;
            fault_d    = 1'b0;
            ic_reset_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wd_q         <= '0;
      stop_pend_q  <= 1'b0;
      frame_cnt_q  <= 16'd0;
      fault_q      <= 1'b0;
      seq_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      ic_reset_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      stop_pend_q  <= stop_pend_d;
      frame_cnt_q  <= frame_cnt_d;
      fault_q      <= fault_d;
      seq_err_q    <= seq_err_d;
      frame_done_q <= frame_done_d;
      ic_reset_q   <= ic_reset_d;
    end
  end

endmodule

// File: tb/tb_sfft_r4_frame_ctrl.sv
// Directed bench for sfft_r4_frame_ctrl (NFFT=16, DRAIN_TIMEOUT=256).
module tb_sfft_r4_frame_ctrl;

  localparam int SB = 4;
  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, abort, fault_clr;
  logic        busy, frame_done, fault, seq_err;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  sfft_r4_frame_ctrl_if #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(DW)) bus ();

  sfft_r4_frame_ctrl #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(DW), .DRAIN_TIMEOUT(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .abort       (abort),
    .fault_clr   (fault_clr),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .fault       (fault),
    .seq_err     (seq_err),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      bus.s_valid  = 1'b1;
      bus.s_data_i = 16'(16'h0a00 + i);
      bus.s_data_q = 16'(16'h0b00 + i);
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic done_pulse();
    bus.ic_done_n = 1'b0;
    tick();
    bus.ic_done_n = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0; fault_clr = 1'b0;
    bus.s_valid = 1'b1; bus.s_data_i = '0; bus.s_data_q = '0; bus.ic_done_n = 1'b1;

    // Reset values before any clock edge
    #2;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_ic_valid", 32'(bus.ic_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ic_reset", 32'(bus.ic_reset), 32'd0);
    chk("rst_counter", 32'(bus.ic_counter_data), 32'd0);
    bus.s_valid = 1'b0;
    tick(); tick();

    // Release: first edge ignored, second edge operational
    reset = 1'b1; start = 1'b1;
    tick();
    chk("sync_edge1_idle", 32'(dbg_state), 32'd0);
    tick();
    chk("sync_edge2_collect", 32'(dbg_state), 32'd1);
    start = 1'b0;
    chk("start_idx0", 32'(bus.ic_counter_data), 32'd0);

    // First frame: 16 beats with per-beat checks
    for (int i = 0; i < 16; i++) begin
      bus.s_valid  = 1'b1;
      bus.s_data_i = 16'(16'h1000 + i);
      bus.s_data_q = 16'(16'h2000 + i);
      #1;
      chk("f1_counter", 32'(bus.ic_counter_data), 32'(i));
      chk("f1_s_ready", 32'(bus.s_ready), 32'd1);
      chk("f1_ic_valid", 32'(bus.ic_valid), 32'd1);
      chk("f1_data_i", 32'(bus.ic_data_i), 32'(16'h1000 + i));
      chk("f1_data_q", 32'(bus.ic_data_q), 32'(16'h2000 + i));
      tick();
    end
    chk("f1_drain", 32'(dbg_state), 32'd2);
    chk("f1_s_ready_off", 32'(bus.s_ready), 32'd0);
    chk("f1_ic_valid_off", 32'(bus.ic_valid), 32'd0);
    chk("f1_busy", 32'(busy), 32'd1);
    bus.s_valid = 1'b0;

    // Drain completion
    tick(); tick(); tick();
    chk("f1_fd_before", 32'(frame_done), 32'd0);
    done_pulse();
    chk("f1_collect", 32'(dbg_state), 32'd1);
    chk("f1_frame_done", 32'(frame_done), 32'd1);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_counter0", 32'(bus.ic_counter_data), 32'd0);
    chk("f1_seq_err", 32'(seq_err), 32'd0);
    tick();
    chk("f1_fd_pulse_end", 32'(frame_done), 32'd0);

    // Second frame: idle gap holds index, stop at beat 5
    beats(3);
    tick(); tick();
    chk("hold_counter", 32'(bus.ic_counter_data), 32'd3);
    chk("hold_state", 32'(dbg_state), 32'd1);
    for (int i = 3; i < 16; i++) begin
      bus.s_valid = 1'b1;
      stop = (i == 5);
      tick();
    end
    stop = 1'b0; bus.s_valid = 1'b0;
    chk("f2_drain", 32'(dbg_state), 32'd2);
    done_pulse();
    chk("f2_idle", 32'(dbg_state), 32'd0);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("f2_s_ready", 32'(bus.s_ready), 32'd0);
    chk("f2_busy", 32'(busy), 32'd0);

    // Drain timeout
    start = 1'b1; tick(); start = 1'b0;
    beats(16);
    chk("to_drain", 32'(dbg_state), 32'd2);
    for (int i = 0; i < 255; i++) tick();
    chk("to_still_drain", 32'(dbg_state), 32'd2);
    chk("to_no_fault_yet", 32'(fault), 32'd0);
    tick();
    chk("to_fault_state", 32'(dbg_state), 32'd3);
    chk("to_fault", 32'(fault), 32'd1);
    bus.s_valid = 1'b1; #1;
    chk("to_s_ready", 32'(bus.s_ready), 32'd0);
    chk("to_ic_valid", 32'(bus.ic_valid), 32'd0);
    bus.s_valid = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("fault_abort_ignored", 32'(dbg_state), 32'd3);
    chk("fault_abort_no_icrst", 32'(bus.ic_reset), 32'd0);
    done_pulse();
    chk("fault_seq_err", 32'(seq_err), 32'd1);
    chk("fault_seq_state", 32'(dbg_state), 32'd3);
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("clr_idle", 32'(dbg_state), 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_ic_reset", 32'(bus.ic_reset), 32'd1);
    chk("clr_seq_err", 32'(seq_err), 32'd0);
    tick();
    chk("clr_ic_reset_end", 32'(bus.ic_reset), 32'd0);
    chk("clr_frame_cnt", 32'(frame_cnt), 32'd2);

    // Abort at beat 9
    start = 1'b1; tick(); start = 1'b0;
    beats(9);
    chk("ab_counter9", 32'(bus.ic_counter_data), 32'd9);
    bus.s_valid = 1'b1; abort = 1'b1;
    tick();
    bus.s_valid = 1'b0; abort = 1'b0;
    chk("ab_idle", 32'(dbg_state), 32'd0);
    chk("ab_ic_reset", 32'(bus.ic_reset), 32'd1);
    chk("ab_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("ab_counter0", 32'(bus.ic_counter_data), 32'd0);
    tick();
    chk("ab_ic_reset_end", 32'(bus.ic_reset), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("ab_restart", 32'(dbg_state), 32'd1);
    chk("ab_restart_idx", 32'(bus.ic_counter_data), 32'd0);

    // Completion coincident with timeout wins
    beats(16);
    for (int i = 0; i < 255; i++) tick();
    done_pulse();
    chk("tie_collect", 32'(dbg_state), 32'd1);
    chk("tie_fault", 32'(fault), 32'd0);
    chk("tie_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("tie_frame_done", 32'(frame_done), 32'd1);

    // start ignored outside IDLE
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ignored", 32'(dbg_state), 32'd1);

    // seq_err in IDLE, stop ignored in IDLE
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_again", 32'(dbg_state), 32'd0);
    done_pulse();
    chk("idle_seq_err", 32'(seq_err), 32'd1);
    chk("idle_seq_state", 32'(dbg_state), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    beats(16);
    done_pulse();
    chk("idle_stop_ignored", 32'(dbg_state), 32'd1);
    chk("f4_frame_cnt", 32'(frame_cnt), 32'd4);

    // Asynchronous reset mid-COLLECT
    beats(4);
    chk("mid_counter", 32'(bus.ic_counter_data), 32'd4);
    bus.s_valid = 1'b1;
    reset = 1'b0;
    #2;
    chk("ar_state", 32'(dbg_state), 32'd0);
    chk("ar_s_ready", 32'(bus.s_ready), 32'd0);
    chk("ar_ic_valid", 32'(bus.ic_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("ar_seq_err", 32'(seq_err), 32'd0);
    chk("ar_counter", 32'(bus.ic_counter_data), 32'd0);
    chk("ar_fault", 32'(fault), 32'd0);
    tick();
    chk("ar_no_frame_done", 32'(frame_done), 32'd0);
    chk("ar_ic_reset", 32'(bus.ic_reset), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
